// File: rtl/wram_arbiter_if.sv
// Work-RAM arbiter bus bundle: two requester ports plus the SRAM pin side.
// slave = arbiter view, master = requester/SRAM-model view.
interface wram_if #(
    parameter int ADDR_W = 23
) ();
    // port A
    logic              a_req;
    logic [1:0]        a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [15:0]       a_dati;
    logic [15:0]       a_dato;
    logic              a_ack;
    // port B
    logic              b_req;
    logic [1:0]        b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [15:0]       b_dati;
    logic [15:0]       b_dato;
    logic              b_ack;
    // SRAM side
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_dati;
    logic [1:0]        mem_we;
    logic              mem_oe;
    logic [15:0]       mem_dato;

    modport slave (
        input  a_req, a_we, a_addr, a_dati,
        output a_dato, a_ack,
        input  b_req, b_we, b_addr, b_dati,
        output b_dato, b_ack,
        output mem_addr, mem_dati, mem_we, mem_oe,
        input  mem_dato
    );

    modport master (
        output a_req, a_we, a_addr, a_dati,
        input  a_dato, a_ack,
        output b_req, b_we, b_addr, b_dati,
        input  b_dato, b_ack,
        input  mem_addr, mem_dati, mem_we, mem_oe,
        output mem_dato
    );
endinterface

// File: rtl/wram_arbiter.sv
// Two-port round-robin arbiter for the shared 16-bit work-RAM.
// Each grant runs a fixed ACC_CYC-cycle strobe window followed by one
// turnaround cycle; all SRAM-side signals come straight from registers.
module wram_arbiter #(
    parameter int ACC_CYC = 2,
    parameter int ADDR_W  = 23
) (
    input  logic  clk,
    input  logic  rst,
    wram_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);

    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic              r_ptr;      // 0 = A has priority on collision, 1 = B
    logic              r_sel;      // current winner, 0 = A, 1 = B
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_dati;
    logic [1:0]        r_we;
    logic              r_oe;
    logic              r_a_ack, r_b_ack;
    logic [15:0]       r_a_dato, r_b_dato;

    logic              w_grant, w_gsel, w_done;
    logic [1:0]        w_we;

    // Next-state and grant decode; requests only matter in IDLE.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_gsel  = r_ptr;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    w_grant = 1'b1;
                    w_gsel  = (bus.a_req && bus.b_req) ? r_ptr : bus.b_req;
                    w_next  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_done = 1'b1;
                    w_next = S_RECOVER;
                end
            end
            S_RECOVER: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_we = w_gsel ? bus.b_we : bus.a_we;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Grant latch, strobe window and access counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_ptr  <= 1'b0;
            r_sel  <= 1'b0;
            r_addr <= '0;
            r_dati <= '0;
            r_we   <= 2'b00;
            r_oe   <= 1'b0;
        end else if (w_grant) begin
            // The loser (or the idle port) gets priority next time.
            r_ptr  <= ~w_gsel;
            r_sel  <= w_gsel;
            r_addr <= w_gsel ? bus.b_addr : bus.a_addr;
            r_dati <= w_gsel ? bus.b_dati : bus.a_dati;
            r_we   <= w_we;
            r_oe   <= (w_we == 2'b00);
            r_cnt  <= CNT_INIT;
        end else if (w_done) begin
            r_we   <= 2'b00;
            r_oe   <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    // Completion: one-cycle ack to the winner, read data captured with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_a_dato <= '0;
            r_b_dato <= '0;
        end else begin
            r_a_ack <= w_done && !r_sel;
            r_b_ack <= w_done &&  r_sel;
            if (w_done && r_oe && !r_sel) r_a_dato <= bus.mem_dato;
            if (w_done && r_oe &&  r_sel) r_b_dato <= bus.mem_dato;
        end
    end

    assign bus.mem_addr = r_addr;
    assign bus.mem_dati = r_dati;
    assign bus.mem_we   = r_we;
    assign bus.mem_oe   = r_oe;
    assign bus.a_ack    = r_a_ack;
    assign bus.b_ack    = r_b_ack;
    assign bus.a_dato   = r_a_dato;
    assign bus.b_dato   = r_b_dato;
endmodule

// File: tb/tb_wram_arbiter.sv
// Directed bench for wram_arbiter: ACC_CYC=2 instance for the main
// scenarios, ACC_CYC=1 instance for the short-access timing.
module tb_wram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wram_if #(.ADDR_W(23)) w0 ();
    wram_if #(.ADDR_W(23)) w1 ();

    wram_arbiter #(.ACC_CYC(2), .ADDR_W(23)) u_dut (.clk(clk), .rst(rst), .bus(w0.slave));
    wram_arbiter #(.ACC_CYC(1), .ADDR_W(23)) u_dut1 (.clk(clk), .rst(rst), .bus(w1.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Observation window results for port w0.
    int          c_oe, c_we, c_aack, c_back;
    logic [15:0] s_adato;
    logic [1:0]  s_we;
    int          ack_who[$];
    int          ack_at[$];

    // Step ncyc cycles, sampling on falling edges; a requester not told to
    // hold drops req on the edge that ends its RECOVER cycle.
    task automatic watch(input int ncyc, input bit hold_a, input bit hold_b);
        bit sa, sb;
        c_oe = 0; c_we = 0; c_aack = 0; c_back = 0;
        ack_who.delete();
        ack_at.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (w0.mem_oe) c_oe++;
            if (w0.mem_we != 2'b00) begin c_we++; s_we = w0.mem_we; end
            sa = w0.a_ack;
            sb = w0.b_ack;
            if (sa) begin c_aack++; s_adato = w0.a_dato; ack_who.push_back(0); ack_at.push_back(i); end
            if (sb) begin c_back++; ack_who.push_back(1); ack_at.push_back(i); end
            @(posedge clk); #1;
            if (sa && !hold_a) w0.a_req = 1'b0;
            if (sb && !hold_b) w0.b_req = 1'b0;
        end
    endtask

    // Continuous invariants on both instances.
    logic [22:0] p0_addr, p1_addr;
    logic        p0_act = 1'b0, p1_act = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("oe_we_excl0", 32'(w0.mem_oe && (w0.mem_we != 2'b00)), 32'd0);
            chk("ack_1hot0",   32'(w0.a_ack && w0.b_ack), 32'd0);
            chk("oe_we_excl1", 32'(w1.mem_oe && (w1.mem_we != 2'b00)), 32'd0);
            chk("ack_1hot1",   32'(w1.a_ack && w1.b_ack), 32'd0);
            if (p0_act && (w0.mem_oe || w0.mem_we != 2'b00))
                chk("addr_stable0", 32'(w0.mem_addr), 32'(p0_addr));
            if (p1_act && (w1.mem_oe || w1.mem_we != 2'b00))
                chk("addr_stable1", 32'(w1.mem_addr), 32'(p1_addr));
        end
        p0_act  <= (w0.mem_oe || w0.mem_we != 2'b00) && !rst;
        p0_addr <= w0.mem_addr;
        p1_act  <= (w1.mem_oe || w1.mem_we != 2'b00) && !rst;
        p1_addr <= w1.mem_addr;
    end

    int t6_oe, t6_ack;
    int t6_at[$];

    initial begin
        w0.a_req = 1'b0; w0.a_we = 2'b00; w0.a_addr = '0; w0.a_dati = '0;
        w0.b_req = 1'b0; w0.b_we = 2'b00; w0.b_addr = '0; w0.b_dati = '0;
        w0.mem_dato = 16'hA55A;
        w1.a_req = 1'b0; w1.a_we = 2'b00; w1.a_addr = 23'h000777; w1.a_dati = '0;
        w1.b_req = 1'b0; w1.b_we = 2'b00; w1.b_addr = '0; w1.b_dati = '0;
        w1.mem_dato = 16'h1234;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_oe",    32'(w0.mem_oe), 32'd0);
        chk("rst_we",    32'(w0.mem_we), 32'd0);
        chk("rst_aack",  32'(w0.a_ack), 32'd0);
        chk("rst_back",  32'(w0.b_ack), 32'd0);
        chk("rst_addr",  32'(w0.mem_addr), 32'd0);
        chk("rst_dati",  32'(w0.mem_dati), 32'd0);
        chk("rst_adato", 32'(w0.a_dato), 32'd0);
        chk("rst_bdato", 32'(w0.b_dato), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: A read
        w0.a_addr = 23'h000040; w0.a_we = 2'b00; w0.a_req = 1'b1;
        watch(8, 1'b0, 1'b0);
        chk("t1_oe_cyc", c_oe, 2);
        chk("t1_we_cyc", c_we, 0);
        chk("t1_aack",   c_aack, 1);
        chk("t1_back",   c_back, 0);
        chk("t1_adato",  32'(s_adato), 32'h0000A55A);
        chk("t1_ack_at", (ack_at.size() > 0) ? ack_at[0] : -1, 3);
        chk("t1_addr",   32'(w0.mem_addr), 32'h40);

        // 2: B byte write
        w0.b_addr = 23'h000123; w0.b_dati = 16'hBEEF; w0.b_we = 2'b10; w0.b_req = 1'b1;
        watch(8, 1'b0, 1'b0);
        chk("t2_we_cyc", c_we, 2);
        chk("t2_we_val", 32'(s_we), 32'd2);
        chk("t2_oe_cyc", c_oe, 0);
        chk("t2_back",   c_back, 1);
        chk("t2_aack",   c_aack, 0);
        chk("t2_addr",   32'(w0.mem_addr), 32'h123);
        chk("t2_dati",   32'(w0.mem_dati), 32'hBEEF);

        // 3: collisions from reset alternate A,B,A,B every 4 cycles
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        w0.b_we = 2'b00;
        w0.a_req = 1'b1; w0.b_req = 1'b1;
        watch(16, 1'b1, 1'b1);
        w0.a_req = 1'b0; w0.b_req = 1'b0;
        chk("t3_nack", ack_who.size(), 4);
        for (int k = 0; k < ack_who.size() && k < 4; k++) begin
            chk("t3_order", ack_who[k], k % 2);
            if (k > 0) chk("t3_spacing", ack_at[k] - ack_at[k-1], 4);
        end

        // 4: A back-to-back, then B joins
        w0.a_req = 1'b1;
        watch(12, 1'b1, 1'b0);
        chk("t4_aack",   c_aack, 3);
        chk("t4_back",   c_back, 0);
        chk("t4_period", (ack_at.size() > 1) ? ack_at[1] - ack_at[0] : -1, 4);
        w0.b_req = 1'b1;
        watch(12, 1'b1, 1'b0);
        w0.a_req = 1'b0;
        chk("t4_b_served", c_back, 1);
        chk("t4_b_first",  (ack_who.size() > 0) ? ack_who[0] : -1, 1);
        chk("t4_b_wait",   32'((ack_at.size() > 0) && (ack_at[0] <= 8)), 32'd1);

        // 5: reset during ACCESS
        w0.a_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_oe_before", 32'(w0.mem_oe), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_oe_async", 32'(w0.mem_oe), 32'd0);
        chk("t5_we_async", 32'(w0.mem_we), 32'd0);
        w0.a_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        watch(4, 1'b0, 1'b0);
        chk("t5_noack", c_aack + c_back, 0);
        w0.a_req = 1'b1; w0.b_req = 1'b1;
        watch(8, 1'b0, 1'b0);
        chk("t5_nack",  ack_who.size(), 2);
        chk("t5_first", (ack_who.size() > 0) ? ack_who[0] : -1, 0);

        // 6: ACC_CYC=1 instance, A back-to-back reads
        t6_oe = 0; t6_ack = 0;
        w1.a_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (w1.mem_oe) t6_oe++;
            if (w1.a_ack) begin t6_ack++; t6_at.push_back(i); end
        end
        @(posedge clk); #1 w1.a_req = 1'b0;
        chk("t6_oe_cyc", t6_oe, 3);
        chk("t6_ack",    t6_ack, 3);
        chk("t6_ack_at", (t6_at.size() > 0) ? t6_at[0] : -1, 2);
        chk("t6_period", (t6_at.size() > 1) ? t6_at[1] - t6_at[0] : -1, 3);
        chk("t6_dato",   32'(w1.a_dato), 32'h1234);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
